// File: rtl/fourier_pkg.sv
// Shared types and default sizing for the RNS Fourier datapath and its sequencer.
package fourier_pkg;

    localparam int unsigned FOURIER_N       = 16;
    localparam int unsigned FOURIER_MAC_LAT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StWrite
    } fctrl_state_t;

endpackage

// File: rtl/fourier_phase_acc.sv
// Running-sum twiddle phase: clear to zero, or add k each enabled cycle (natural ADDR_W wrap).
module fourier_phase_acc #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [ADDR_W-1:0] k,
    output logic [ADDR_W-1:0] phase
);

    logic [ADDR_W-1:0] phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else if (clear) begin
            phase_q <= '0;
        end else if (add) begin
            phase_q <= phase_q + k;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/fourier_ctrl.sv
// Bin-by-bin DFT sequencer: clear accumulators, stream sample/twiddle addresses, drain, write.
module fourier_ctrl
    import fourier_pkg::*;
#(
    parameter int unsigned N       = FOURIER_N,
    parameter int unsigned ADDR_W  = $clog2(N),
    parameter int unsigned MAC_LAT = FOURIER_MAC_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sampleAddr,
    output logic [ADDR_W-1:0] twiddleAddr,
    output logic              macClear,
    output logic              macEn,
    output logic              resWe,
    output logic [ADDR_W-1:0] resAddr
);

    localparam int unsigned CntW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(N - 1);
    localparam logic [CntW-1:0]   DrainLast = CntW'(MAC_LAT - 1);

    fctrl_state_t      state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              phase_clr, phase_add;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        phase_clr = 1'b0;
        phase_add = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    k_d     = '0;
                    done_d  = 1'b0;
                end
            end
            StClear: begin
                n_d       = '0;
                phase_clr = 1'b1;
                state_d   = StRun;
            end
            StRun: begin
                n_d       = n_q + 1'b1;
                phase_add = 1'b1;
                cnt_d     = '0;
                if (n_q == LastIdx) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                if (k_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StClear;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over every transition, including completion from the final write.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = done_q;
        end
    end

    fourier_phase_acc #(
        .ADDR_W(ADDR_W)
    ) u_phase_acc (
        .clk  (clk),
        .reset(reset),
        .clear(phase_clr),
        .add  (phase_add),
        .k    (k_q),
        .phase(twiddleAddr)
    );

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign sampleAddr = n_q;
    assign resAddr    = k_q;
    assign macClear   = (state_q == StClear);
    assign macEn      = (state_q == StRun);
    assign resWe      = (state_q == StWrite);

endmodule
